// File: rtl/gru_sequence_feeder.sv
// gru_sequence_feeder: sliding sample window feeding GRU_Model, with start/done sequencing and a
// valid/ready result stream. Define GRU_FEEDER_TIMEOUT_EN to enable the done watchdog.
module gru_sequence_feeder #(
    parameter int DATA_WIDTH      = 32,
    parameter int INPUT_FEATURES  = 3,
    parameter int SEQUENCE_LENGTH = 3,
    parameter int STRIDE          = 3,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 i_s_valid,
    output logic                                                 o_s_ready,
    input  logic [DATA_WIDTH-1:0]                                i_s_data,
    output logic                                                 o_gru_start,
    input  logic                                                 i_gru_done,
    output logic [SEQUENCE_LENGTH*INPUT_FEATURES*DATA_WIDTH-1:0] o_sequence_flat,
    input  logic [DATA_WIDTH-1:0]                                i_gru_prediction,
    output logic                                                 o_m_valid,
    input  logic                                                 i_m_ready,
    output logic [DATA_WIDTH-1:0]                                o_m_data,
    output logic                                                 o_m_err,
    output logic [15:0]                                          o_infer_count
);
    localparam int W  = SEQUENCE_LENGTH * INPUT_FEATURES;
    localparam int FW = $clog2(W + 1);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    if (STRIDE < 1 || STRIDE > W || TIMEOUT_CYCLES < 1 || W < 2) begin : g_bad_cfg
        $error("gru_sequence_feeder: illegal STRIDE/TIMEOUT_CYCLES/window configuration");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_OUT,
        S_WAIT_LOW
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [W*DATA_WIDTH-1:0] r_window;
    logic [W*DATA_WIDTH-1:0] r_seq;
    logic [FW-1:0]           r_fill_cnt;
    logic [SW-1:0]           r_stride_cnt;
    logic                    r_pending;
    logic                    r_gru_start;
    logic                    r_m_valid;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [15:0]             r_infer_count;
    logic                    w_accept;
    logic                    w_launch;
    logic                    w_result;
    logic                    w_release;
`ifdef GRU_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           r_timer;
    logic                    r_m_err;
    logic                    w_timeout;
`endif

    assign o_s_ready       = ~r_pending;
    assign w_accept        = i_s_valid & ~r_pending;
    assign o_gru_start     = r_gru_start;
    assign o_sequence_flat = r_seq;
    assign o_m_valid       = r_m_valid;
    assign o_m_data        = r_m_data;
    assign o_infer_count   = r_infer_count;
`ifdef GRU_FEEDER_TIMEOUT_EN
    assign o_m_err         = r_m_err;
`else
    assign o_m_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_result  = 1'b0;
        w_release = 1'b0;
`ifdef GRU_FEEDER_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // A done left high from the previous run must fall before the next launch
                if (r_pending && !i_gru_done) begin
                    w_launch = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START: w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_gru_done) begin
                    w_result = 1'b1;
                    w_next   = S_OUT;
                end
`ifdef GRU_FEEDER_TIMEOUT_EN
                else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_OUT;
                end
`endif
            end
            S_OUT: begin
                if (i_m_ready) begin
                    w_release = 1'b1;
                    w_next    = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!i_gru_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_window      <= '0;
            r_seq         <= '0;
            r_fill_cnt    <= '0;
            r_stride_cnt  <= '0;
            r_pending     <= 1'b0;
            r_gru_start   <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_infer_count <= '0;
`ifdef GRU_FEEDER_TIMEOUT_EN
            r_timer       <= '0;
            r_m_err       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_window <= {i_s_data, r_window[W*DATA_WIDTH-1:DATA_WIDTH]};
                // The filling word triggers by itself; stride counting starts after it
                if (r_fill_cnt != FW'(W)) begin
                    r_fill_cnt <= r_fill_cnt + FW'(1);
                    if (r_fill_cnt == FW'(W - 1)) begin
                        r_pending    <= 1'b1;
                        r_stride_cnt <= '0;
                    end
                end else if (r_stride_cnt == SW'(STRIDE - 1)) begin
                    r_pending    <= 1'b1;
                    r_stride_cnt <= '0;
                end else begin
                    r_stride_cnt <= r_stride_cnt + SW'(1);
                end
            end
            if (w_launch) begin
                r_seq     <= r_window;
                r_pending <= 1'b0;
            end
            r_gru_start <= w_launch;
            if (w_result) begin
                r_m_data      <= i_gru_prediction;
                r_m_valid     <= 1'b1;
                r_infer_count <= r_infer_count + 16'd1;
`ifdef GRU_FEEDER_TIMEOUT_EN
                r_m_err       <= 1'b0;
`endif
            end
`ifdef GRU_FEEDER_TIMEOUT_EN
            if (w_timeout) begin
                r_m_data  <= DATA_WIDTH'(32'h7FC0_0000);
                r_m_err   <= 1'b1;
                r_m_valid <= 1'b1;
            end
            r_timer <= (r_state == S_WAIT_DONE) ? r_timer + TW'(1) : '0;
`endif
            if (w_release) begin
                r_m_valid <= 1'b0;
            end
        end
    end

endmodule
